// File: rtl/seq_divider_if.sv
// Handshake and data bundle for the sequential divider.
//   start, dividend, divisor          : requester -> divider
//   busy, done, quotient, remainder,
//   valid                             : divider -> requester
// master = requester side (ALU control), slave = divider side.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             valid;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, valid
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, valid
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, aborts any division in flight
//   bus    : seq_divider_if slave modport
//            start/dividend/divisor sampled in IDLE only;
//            busy high for WIDTH cycles per accepted division;
//            done pulses one cycle when quotient/remainder/valid update;
//            valid=0 marks a divide-by-zero result (q=0, r=dividend).
// All outputs come straight from registers.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;       // partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;     // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  // The partial remainder is always below the divisor between steps, so it is
  // stored in WIDTH bits and only the shifted trial value is WIDTH+1 bits.
  // For the same reason the trial is below 2*divisor, so the top bit of the
  // WIDTH+1-bit difference is exactly the borrow: clear means trial >= divisor.
  always_comb begin
    trial  = {r_q, sh_q[WIDTH-1]};
    diff   = trial - {1'b0, dvs_q};
    fits   = ~diff[WIDTH];
    r_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    q_step = {sh_q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            dvs_d   = bus.divisor;
            r_d     = '0;
            sh_d    = bus.dividend;
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            quot_d  = '0;
            rem_d   = bus.dividend;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      CALC: begin
        r_d   = r_step;
        sh_d  = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quot_d  = q_step;
          rem_d   = r_step;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      sh_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      sh_q    <= sh_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q == CALC);
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.valid     = valid_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed cases followed by
// randomized operands, checked against plain '/' and '%' arithmetic.
module tb_seq_divider;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [W-1:0] last_q;
  logic [W-1:0] last_r;
  logic         last_v;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ordinary integer division; divide-by-zero gives q=0, r=a, invalid.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic v);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q = '0;
      r = a;
      v = 1'b0;
    end else begin
      q = W'(ai / bi);
      r = W'(ai % bi);
      v = 1'b1;
    end
  endtask

  task automatic chk_outs(input string tag, input logic [W-1:0] q,
                          input logic [W-1:0] r, input logic v);
    chk({tag, ".q"}, 32'(bus.quotient), 32'(q));
    chk({tag, ".r"}, 32'(bus.remainder), 32'(r));
    chk({tag, ".v"}, 32'(bus.valid), 32'(v));
  endtask

  // Issue one division. Caller leaves the bus in IDLE (possibly the done
  // cycle of a previous result). hold: spend one more cycle checking that
  // done drops and results stay. poke: raise start with 9/2 while busy.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit poke);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ev;
    model(a, b, eq, er, ev);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    if (b == '0) begin
      chk("dz.busy", 32'(bus.busy), 32'd0);
      chk("dz.done", 32'(bus.done), 32'd1);
    end else begin
      for (int i = 0; i < W; i++) begin
        chk("run.busy", 32'(bus.busy), 32'd1);
        chk("run.done", 32'(bus.done), 32'd0);
        chk_outs("run.held", last_q, last_r, last_v);
        if (poke && i == 0) begin
          bus.start    = 1'b1;
          bus.dividend = 4'd9;
          bus.divisor  = 4'd2;
        end else begin
          bus.start = 1'b0;
        end
        tick();
      end
      bus.start = 1'b0;
      chk("end.busy", 32'(bus.busy), 32'd0);
      chk("end.done", 32'(bus.done), 32'd1);
    end
    chk_outs("result", eq, er, ev);
    last_q = eq;
    last_r = er;
    last_v = ev;
    if (hold) begin
      tick();
      chk("after.done", 32'(bus.done), 32'd0);
      chk("after.busy", 32'(bus.busy), 32'd0);
      chk_outs("after.held", eq, er, ev);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    last_q       = '0;
    last_r       = '0;
    last_v       = 1'b0;

    #12;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk_outs("rst", 4'd0, 4'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic, divide-by-zero, boundary sweep.
    do_div(4'd13, 4'd3, 1'b1, 1'b0);
    do_div(4'd5,  4'd0, 1'b1, 1'b0);
    do_div(4'd2,  4'd7, 1'b1, 1'b0);
    do_div(4'd15, 4'd1, 1'b1, 1'b0);
    do_div(4'd0,  4'd9, 1'b1, 1'b0);
    do_div(4'd15, 4'd15, 1'b1, 1'b0);

    // Start while busy is ignored.
    do_div(4'd12, 4'd5, 1'b1, 1'b1);

    // Back-to-back: second start in the done cycle of the first.
    do_div(4'd14, 4'd4, 1'b0, 1'b0);
    do_div(4'd7,  4'd3, 1'b1, 1'b0);

    // Reset during the 2nd busy cycle aborts with no done.
    bus.start    = 1'b1;
    bus.dividend = 4'd11;
    bus.divisor  = 4'd2;
    tick();
    bus.start = 1'b0;
    chk("abort.busy1", 32'(bus.busy), 32'd1);
    tick();
    chk("abort.busy2", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk_outs("abort", 4'd0, 4'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    last_q = '0;
    last_r = '0;
    last_v = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("abort.nodone", 32'(bus.done), 32'd0);
      chk("abort.idle", 32'(bus.busy), 32'd0);
    end
    do_div(4'd11, 4'd2, 1'b1, 1'b0);

    // Randomized operands, random back-to-back and busy pokes.
    for (int k = 0; k < 60; k++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 6) == 0) ? '0 : W'($urandom);
      do_div(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    tick();
    chk("final.done", 32'(bus.done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
